// File: rtl/cond_pkg.sv
// Shared types for the branch condition unit: ARM condition codes, the
// resolver state encoding, the N/Z/V/C flag bundle and the condition evaluator.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } flags_t;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // NV is treated as "always" rather than "never", matching the unit's contract.
    function automatic logic cond_holds(input cond_e cond, input flags_t f);
        logic result;
        case (cond)
            COND_EQ: result = f.z;
            COND_NE: result = !f.z;
            COND_CS: result = f.c;
            COND_CC: result = !f.c;
            COND_MI: result = f.n;
            COND_PL: result = !f.n;
            COND_VS: result = f.v;
            COND_VC: result = !f.v;
            COND_HI: result = f.c && !f.z;
            COND_LS: result = !f.c || f.z;
            COND_GE: result = (f.n == f.v);
            COND_LT: result = (f.n != f.v);
            COND_GT: result = !f.z && (f.n == f.v);
            COND_LE: result = f.z || (f.n != f.v);
            COND_AL: result = 1'b1;
            COND_NV: result = 1'b1;
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/branch_cond_unit_if.sv
// Request/response handshake between a branch issuer (master) and the
// condition resolver (slave).
interface branch_cond_unit_if;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] cond;
    logic       resp_valid;
    logic       resp_ready;
    logic       take;

    modport master (
        output req_valid,
        output cond,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  take
    );

    modport slave (
        input  req_valid,
        input  cond,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output take
    );
endinterface

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator: cond plus N/Z/V/C in, take out.
module cond_eval
    import cond_pkg::*;
(
    input  cond_e cond,
    input  logic  negative,
    input  logic  zero,
    input  logic  overflow,
    input  logic  carry_out,
    output logic  take
);

    flags_t flags;

    always_comb begin
        flags = '{n: negative, z: zero, v: overflow, c: carry_out};
        take  = cond_holds(cond, flags);
    end

endmodule

// File: rtl/branch_cond_unit.sv
// Branch condition resolver: waits for flag hazards to clear, evaluates the
// condition once, holds the decision until consumed. Define FLAG_BYPASS_EN to
// forward same-cycle flag-register writes instead of stalling on them.
module branch_cond_unit
    import cond_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              negative_o,
    input  logic              zero_o,
    input  logic              overflow_o,
    input  logic              carry_out_o,
    input  logic              wr_en,
    input  logic              negative,
    input  logic              zero,
    input  logic              overflow,
    input  logic              carry_out,
    input  logic              flags_pending,
    branch_cond_unit_if.slave bus,
    output logic [CNT_W-1:0]  taken_count
);

    state_e            state_reg, state_next;
    cond_e             cond_reg, cond_next;
    logic              take_reg, take_next;
    logic [CNT_W-1:0]  count_reg, count_next;

    flags_t            stored_flags;
    flags_t            write_flags;
    flags_t            eff_flags;
    logic              flags_ready;
    cond_e             eval_cond;
    logic              eval_take;

    assign stored_flags = '{n: negative_o, z: zero_o, v: overflow_o, c: carry_out_o};
    assign write_flags  = '{n: negative,   z: zero,   v: overflow,   c: carry_out};

    // Without bypass a write cycle is never "ready", so forwarding here is harmless.
    assign eff_flags = wr_en ? write_flags : stored_flags;

`ifdef FLAG_BYPASS_EN
    assign flags_ready = !flags_pending;
`else
    assign flags_ready = !flags_pending && !wr_en;
`endif

    // In IDLE the live request code is evaluated so a hazard-free request resolves at acceptance.
    assign eval_cond = (state_reg == ST_IDLE) ? cond_e'(bus.cond) : cond_reg;

    cond_eval u_cond_eval (
        .cond      (eval_cond),
        .negative  (eff_flags.n),
        .zero      (eff_flags.z),
        .overflow  (eff_flags.v),
        .carry_out (eff_flags.c),
        .take      (eval_take)
    );

    always_comb begin
        state_next = state_reg;
        cond_next  = cond_reg;
        take_next  = take_reg;
        count_next = count_reg;

        case (state_reg)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    cond_next = cond_e'(bus.cond);
                    if (flags_ready) begin
                        state_next = ST_RESP;
                        take_next  = eval_take;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (flags_ready) begin
                    state_next = ST_RESP;
                    take_next  = eval_take;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_next = ST_IDLE;
                    take_next  = 1'b0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                take_next  = 1'b0;
            end
        endcase

        if ((state_next == ST_RESP) && (state_reg != ST_RESP) && take_next
                && (count_reg != CNT_MAX)) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cond_reg  <= COND_EQ;
            take_reg  <= 1'b0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            cond_reg  <= cond_next;
            take_reg  <= take_next;
            count_reg <= count_next;
        end
    end

    assign bus.req_ready  = (state_reg == ST_IDLE);
    assign bus.resp_valid = (state_reg == ST_RESP);
    assign bus.take       = take_reg && (state_reg == ST_RESP);
    assign taken_count    = count_reg;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Scoreboard bench for branch_cond_unit: directed vectors push expected
// decisions; a negedge monitor pops and compares on every response handshake.
module tb_branch_cond_unit;

    logic        clk;
    logic        reset;
    logic        negative_o, zero_o, overflow_o, carry_out_o;
    logic        wr_en, negative, zero, overflow, carry_out;
    logic        flags_pending;
    logic [15:0] taken_count;

    branch_cond_unit_if bus_if ();

    branch_cond_unit dut (
        .clk           (clk),
        .reset         (reset),
        .negative_o    (negative_o),
        .zero_o        (zero_o),
        .overflow_o    (overflow_o),
        .carry_out_o   (carry_out_o),
        .wr_en         (wr_en),
        .negative      (negative),
        .zero          (zero),
        .overflow      (overflow),
        .carry_out     (carry_out),
        .flags_pending (flags_pending),
        .bus           (bus_if),
        .taken_count   (taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        take;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        logic [3:0] c;
        logic [3:0] nzvc;
        logic       exp;
    } vec_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    bit          quiet = 1'b0;
    logic [15:0] model_cnt = 16'd0;
    vec_t        vecs[24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_flags(input logic [3:0] nzvc);
        negative_o  = nzvc[3];
        zero_o      = nzvc[2];
        overflow_o  = nzvc[1];
        carry_out_o = nzvc[0];
    endtask

    // Present a request until accepted; optionally record the expected response.
    task automatic send(input logic [3:0] c, input logic exp_take, input bit push);
        int n;
        exp_t e;
        n = 0;
        bus_if.req_valid = 1'b1;
        bus_if.cond      = c;
        while (!bus_if.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", {31'd0, bus_if.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
        if (push) begin
            if (exp_take && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
            e.take = exp_take;
            e.cnt  = model_cnt;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle_wait();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((!bus_if.req_ready || exp_q.size() != 0) && n < 100);
        if (!bus_if.req_ready || exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got ready=%0b pending=%0d expected ready=1 pending=0",
                     bus_if.req_ready, exp_q.size());
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus_if.resp_valid && bus_if.resp_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got take=%0b expected no response", bus_if.take);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_take", {31'd0, bus_if.take}, {31'd0, e.take});
                check("resp_count", {16'd0, taken_count}, {16'd0, e.cnt});
                if (!quiet)
                    $display("resp take=%0b taken_count=%0d (expected take=%0b count=%0d)",
                             bus_if.take, taken_count, e.take, e.cnt);
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs = '{
            '{4'h0, 4'b0100, 1'b1}, '{4'h0, 4'b0000, 1'b0},
            '{4'h1, 4'b0000, 1'b1}, '{4'h1, 4'b0100, 1'b0},
            '{4'h2, 4'b0001, 1'b1}, '{4'h3, 4'b0001, 1'b0},
            '{4'h4, 4'b1000, 1'b1}, '{4'h5, 4'b1000, 1'b0},
            '{4'h6, 4'b0010, 1'b1}, '{4'h7, 4'b0000, 1'b1},
            '{4'h8, 4'b0001, 1'b1}, '{4'h8, 4'b0101, 1'b0},
            '{4'h9, 4'b0101, 1'b1}, '{4'h9, 4'b0001, 1'b0},
            '{4'hA, 4'b1010, 1'b1}, '{4'hA, 4'b1000, 1'b0},
            '{4'hB, 4'b0010, 1'b1}, '{4'hB, 4'b0000, 1'b0},
            '{4'hC, 4'b0000, 1'b1}, '{4'hC, 4'b0100, 1'b0},
            '{4'hD, 4'b1000, 1'b1}, '{4'hD, 4'b0000, 1'b0},
            '{4'hE, 4'b0000, 1'b1}, '{4'hF, 4'b1111, 1'b1}
        };

        reset = 1'b1;
        set_flags(4'b0000);
        wr_en = 1'b0; negative = 1'b0; zero = 1'b0; overflow = 1'b0; carry_out = 1'b0;
        flags_pending     = 1'b0;
        bus_if.req_valid  = 1'b0;
        bus_if.cond       = 4'h0;
        bus_if.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", {31'd0, bus_if.req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, bus_if.resp_valid}, 32'd0);
        check("rst_take", {31'd0, bus_if.take}, 32'd0);
        check("rst_count", {16'd0, taken_count}, 32'd0);

        // EQ with stored Z=1, no hazard: one-cycle latency
        set_flags(4'b0100);
        send(4'h0, 1'b1, 1'b1);
        @(negedge clk);
        check("eq_lat1_valid", {31'd0, bus_if.resp_valid}, 32'd1);
        check("eq_lat1_take", {31'd0, bus_if.take}, 32'd1);
        check("eq_count", {16'd0, taken_count}, 32'd1);

        // condition table
        foreach (vecs[i]) begin
            idle_wait();
            set_flags(vecs[i].nzvc);
            send(vecs[i].c, vecs[i].exp, 1'b1);
        end

        // pending hazard for three cycles, LT with N=1 V=0
        idle_wait();
        set_flags(4'b1000);
        flags_pending = 1'b1;
        send(4'hB, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("lt_wait_valid", {31'd0, bus_if.resp_valid}, 32'd0);
            check("lt_wait_ready", {31'd0, bus_if.req_ready}, 32'd0);
        end
        flags_pending = 1'b0;
        @(negedge clk);
        check("lt_resp_valid", {31'd0, bus_if.resp_valid}, 32'd1);
        check("lt_resp_take", {31'd0, bus_if.take}, 32'd1);

        // same-cycle flag write: stored C=0, written C=1, CS
        idle_wait();
        set_flags(4'b0000);
        wr_en = 1'b1;
        carry_out = 1'b1;
        send(4'h2, 1'b1, 1'b1);
        wr_en = 1'b0;
        carry_out = 1'b0;
        carry_out_o = 1'b1;
`ifdef FLAG_BYPASS_EN
        @(negedge clk);
        check("byp_lat1_valid", {31'd0, bus_if.resp_valid}, 32'd1);
        check("byp_lat1_take", {31'd0, bus_if.take}, 32'd1);
`else
        @(negedge clk);
        check("nobyp_lat1_valid", {31'd0, bus_if.resp_valid}, 32'd0);
        @(negedge clk);
        check("nobyp_lat2_valid", {31'd0, bus_if.resp_valid}, 32'd1);
        check("nobyp_lat2_take", {31'd0, bus_if.take}, 32'd1);
`endif

        // back-pressure: resp_ready low for four cycles
        idle_wait();
        bus_if.resp_ready = 1'b0;
        send(4'hE, 1'b1, 1'b1);
        bus_if.req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, bus_if.resp_valid}, 32'd1);
            check("hold_take", {31'd0, bus_if.take}, 32'd1);
            check("hold_req_ready", {31'd0, bus_if.req_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        bus_if.resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("exit_resp_valid", {31'd0, bus_if.resp_valid}, 32'd0);
        check("exit_take", {31'd0, bus_if.take}, 32'd0);
        check("exit_req_ready", {31'd0, bus_if.req_ready}, 32'd1);
        bus_if.req_valid = 1'b0;

        // reset while waiting on a hazard
        idle_wait();
        flags_pending = 1'b1;
        send(4'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("pre_rst_wait_ready", {31'd0, bus_if.req_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        flags_pending = 1'b0;
        model_cnt = 16'd0;
        @(negedge clk);
        check("wait_rst_valid", {31'd0, bus_if.resp_valid}, 32'd0);
        check("wait_rst_count", {16'd0, taken_count}, 32'd0);
        check("wait_rst_ready", {31'd0, bus_if.req_ready}, 32'd1);

        // reset while holding a response
        bus_if.resp_ready = 1'b0;
        send(4'hE, 1'b1, 1'b0);
        @(negedge clk);
        check("pre_rst_resp_valid", {31'd0, bus_if.resp_valid}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus_if.resp_ready = 1'b1;
        model_cnt = 16'd0;
        @(negedge clk);
        check("resp_rst_valid", {31'd0, bus_if.resp_valid}, 32'd0);
        check("resp_rst_take", {31'd0, bus_if.take}, 32'd0);
        check("resp_rst_count", {16'd0, taken_count}, 32'd0);
        check("resp_rst_ready", {31'd0, bus_if.req_ready}, 32'd1);

        // saturation: 65535 taken AL branches, then one more
        $display("running 65535 taken AL branches");
        quiet = 1'b1;
        for (int i = 0; i < 65535; i++) send(4'hE, 1'b1, 1'b1);
        idle_wait();
        check("sat_reach", {16'd0, taken_count}, 32'h0000FFFF);
        quiet = 1'b0;
        send(4'hE, 1'b1, 1'b1);
        idle_wait();
        check("sat_hold", {16'd0, taken_count}, 32'h0000FFFF);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
